// File: rtl/core_wb_data_adapter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : core_wb_data_adapter
// Description : Bridges the core's req/ack data port onto a single-master
//               Wishbone data bus.
//               - Registers each core request and holds cyc/stb until the
//                 slave acknowledges.
//               - Captures read data and returns a one-cycle ack to the core.
//               - Aborts a stalled transfer after a bounded number of bus
//                 cycles and returns ERR_DATA.
// Ports       :
//   clk, rst_n                 clock, synchronous active-low reset
//   core_req_i .. core_mask_i  core request (held until core_ack_o)
//   core_rd_data_o, core_ack_o core completion (data valid with ack)
//   wb_*_o / wb_*_i            Wishbone master side (stb == cyc)
//   timeout_o, timeout_cnt_o   abort pulse and saturating abort count
// Revision    : 1.0 - initial release
// ============================================================================
module core_wb_data_adapter #(
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    TIMEOUT_CYCLES = 255,
    parameter logic [DATA_WIDTH-1:0] ERR_DATA       = 32'hDEADBEEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    // core side
    input  logic                    core_req_i,
    input  logic                    core_wr_en_i,
    input  logic [ADDR_WIDTH-1:0]   core_addr_i,
    input  logic [DATA_WIDTH-1:0]   core_wr_data_i,
    input  logic [DATA_WIDTH/8-1:0] core_mask_i,
    output logic [DATA_WIDTH-1:0]   core_rd_data_o,
    output logic                    core_ack_o,
    // Wishbone side
    output logic                    wb_cyc_o,
    output logic                    wb_stb_o,
    output logic                    wb_we_o,
    output logic [DATA_WIDTH/8-1:0] wb_wstrb_o,
    output logic [ADDR_WIDTH-1:0]   wb_addr_o,
    output logic [DATA_WIDTH-1:0]   wb_data_o,
    input  logic [DATA_WIDTH-1:0]   wb_data_i,
    input  logic                    wb_ack_i,
    // status
    output logic                    timeout_o,
    output logic [7:0]              timeout_cnt_o
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    // Counter only has to reach TIMEOUT_CYCLES-1.
    localparam int CNT_WIDTH  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_BUS  = 2'd1;
    localparam logic [1:0] c_RESP = 2'd2;

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    logic [1:0]            state_q,    state_d;
    logic [ADDR_WIDTH-1:0] addr_q,     addr_d;
    logic [DATA_WIDTH-1:0] wdata_q,    wdata_d;
    logic [STRB_WIDTH-1:0] wstrb_q,    wstrb_d;
    logic                  we_q,       we_d;
    logic                  cyc_q,      cyc_d;
    logic [CNT_WIDTH-1:0]  wait_cnt_q, wait_cnt_d;
    logic [DATA_WIDTH-1:0] rdata_q,    rdata_d;
    logic                  ack_q,      ack_d;
    logic                  to_q,       to_d;
    logic [7:0]            to_cnt_q,   to_cnt_d;

    logic                  w_timeout_hit;

    // ------------------------------------------------------------------
    // Timeout detection; a zero TIMEOUT_CYCLES waits forever.
    // ------------------------------------------------------------------
    generate
        if (TIMEOUT_CYCLES != 0) begin : g_timeout
            localparam logic [CNT_WIDTH-1:0] c_TO_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
            assign w_timeout_hit = (wait_cnt_q == c_TO_LAST);
        end else begin : g_no_timeout
            assign w_timeout_hit = 1'b0;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        we_d       = we_q;
        cyc_d      = cyc_q;
        wait_cnt_d = wait_cnt_q;
        rdata_d    = rdata_q;
        ack_d      = 1'b0;
        to_d       = 1'b0;
        to_cnt_d   = to_cnt_q;

        case (state_q)
            c_IDLE: begin
                if (core_req_i) begin
                    addr_d     = core_addr_i;
                    wdata_d    = core_wr_data_i;
                    we_d       = core_wr_en_i;
                    // Strobes are pre-qualified so reads present all-zero.
                    wstrb_d    = core_wr_en_i ? core_mask_i : '0;
                    wait_cnt_d = '0;
                    cyc_d      = 1'b1;
                    state_d    = c_BUS;
                end
            end

            c_BUS: begin
                wait_cnt_d = wait_cnt_q + 1'b1;
                // Ack is tested first so it wins over a coincident timeout.
                if (wb_ack_i) begin
                    cyc_d   = 1'b0;
                    rdata_d = we_q ? '0 : wb_data_i;
                    ack_d   = 1'b1;
                    state_d = c_RESP;
                end else if (w_timeout_hit) begin
                    cyc_d   = 1'b0;
                    rdata_d = ERR_DATA;
                    ack_d   = 1'b1;
                    to_d    = 1'b1;
                    if (to_cnt_q != 8'hFF) begin
                        to_cnt_d = to_cnt_q + 8'd1;
                    end
                    state_d = c_RESP;
                end
            end

            // core_ack_o is high during this state; the request is not
            // sampled again until IDLE.
            c_RESP: begin
                state_d = c_IDLE;
            end

            default: begin
                state_d = c_IDLE;
                cyc_d   = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= c_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            we_q       <= 1'b0;
            cyc_q      <= 1'b0;
            wait_cnt_q <= '0;
            rdata_q    <= '0;
            ack_q      <= 1'b0;
            to_q       <= 1'b0;
            to_cnt_q   <= 8'd0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            we_q       <= we_d;
            cyc_q      <= cyc_d;
            wait_cnt_q <= wait_cnt_d;
            rdata_q    <= rdata_d;
            ack_q      <= ack_d;
            to_q       <= to_d;
            to_cnt_q   <= to_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs (all straight from registers)
    // ------------------------------------------------------------------
    assign wb_cyc_o       = cyc_q;
    assign wb_stb_o       = cyc_q;
    assign wb_we_o        = we_q;
    assign wb_wstrb_o     = wstrb_q;
    assign wb_addr_o      = addr_q;
    assign wb_data_o      = wdata_q;
    assign core_rd_data_o = rdata_q;
    assign core_ack_o     = ack_q;
    assign timeout_o      = to_q;
    assign timeout_cnt_o  = to_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_core_wb_data_adapter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_core_wb_data_adapter
// Description : Directed self-checking bench for core_wb_data_adapter.
//               Expected completions are queued when a request is driven and
//               compared when the core ack appears.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_core_wb_data_adapter;

    localparam int          AW  = 32;
    localparam int          DW  = 32;
    localparam int          T   = 4;
    localparam logic [31:0] ERR = 32'hDEADBEEF;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          core_req_i = 1'b0;
    logic          core_wr_en_i = 1'b0;
    logic [AW-1:0] core_addr_i = '0;
    logic [DW-1:0] core_wr_data_i = '0;
    logic [3:0]    core_mask_i = '0;
    logic [DW-1:0] core_rd_data_o;
    logic          core_ack_o;
    logic          wb_cyc_o;
    logic          wb_stb_o;
    logic          wb_we_o;
    logic [3:0]    wb_wstrb_o;
    logic [AW-1:0] wb_addr_o;
    logic [DW-1:0] wb_data_o;
    logic [DW-1:0] wb_data_i = '0;
    logic          wb_ack_i = 1'b0;
    logic          timeout_o;
    logic [7:0]    timeout_cnt_o;

    core_wb_data_adapter #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (T),
        .ERR_DATA       (ERR)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .core_req_i     (core_req_i),
        .core_wr_en_i   (core_wr_en_i),
        .core_addr_i    (core_addr_i),
        .core_wr_data_i (core_wr_data_i),
        .core_mask_i    (core_mask_i),
        .core_rd_data_o (core_rd_data_o),
        .core_ack_o     (core_ack_o),
        .wb_cyc_o       (wb_cyc_o),
        .wb_stb_o       (wb_stb_o),
        .wb_we_o        (wb_we_o),
        .wb_wstrb_o     (wb_wstrb_o),
        .wb_addr_o      (wb_addr_o),
        .wb_data_o      (wb_data_o),
        .wb_data_i      (wb_data_i),
        .wb_ack_i       (wb_ack_i),
        .timeout_o      (timeout_o),
        .timeout_cnt_o  (timeout_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rd;
        logic        to;
    } exp_t;

    exp_t sb[$];
    int   checks     = 0;
    int   errors     = 0;
    int   cyc_n      = 0;
    int   exp_to_cnt = 0;

    // Advance one cycle; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rd_data"}, core_rd_data_o, 32'h0);
        chk({tag, "_ack"},     32'(core_ack_o), 32'h0);
        chk({tag, "_cyc"},     32'(wb_cyc_o), 32'h0);
        chk({tag, "_stb"},     32'(wb_stb_o), 32'h0);
        chk({tag, "_we"},      32'(wb_we_o), 32'h0);
        chk({tag, "_wstrb"},   32'(wb_wstrb_o), 32'h0);
        chk({tag, "_addr"},    wb_addr_o, 32'h0);
        chk({tag, "_wdata"},   wb_data_o, 32'h0);
        chk({tag, "_to"},      32'(timeout_o), 32'h0);
        chk({tag, "_to_cnt"},  32'(timeout_cnt_o), 32'h0);
    endtask

    // Drive one request and act as the slave: ack on stb cycle index
    // ack_after (0 = first stb cycle), or never when negative.
    task automatic run_xfer(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                            input logic [3:0] mask, input int ack_after, input logic [31:0] rd,
                            input logic hold, output int lat_stb, output int n_stb,
                            output int lat_ack, output int stb_cyc);
        int   t0;
        int   b;
        bit   timed_out;
        bit   done;
        exp_t e;
        exp_t g;
        t0             = cyc_n;
        core_req_i     = 1'b1;
        core_wr_en_i   = we;
        core_addr_i    = addr;
        core_wr_data_i = wd;
        core_mask_i    = mask;
        timed_out      = (ack_after < 0) || (ack_after >= T);
        e.rd           = timed_out ? ERR : (we ? 32'h0 : rd);
        e.to           = timed_out;
        sb.push_back(e);

        tick();
        chk("ack_low_after_req", 32'(core_ack_o), 32'h0);
        b = 0;
        while (wb_stb_o !== 1'b1 && b < 4) begin
            tick();
            b++;
        end
        lat_stb = cyc_n - t0;
        stb_cyc = cyc_n;
        chk("stb_rise", 32'(wb_stb_o), 32'h1);

        n_stb = 0;
        done  = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
            if (wb_stb_o === 1'b1) begin
                n_stb++;
                chk("bus_cyc",   32'(wb_cyc_o), 32'h1);
                chk("bus_we",    32'(wb_we_o), 32'(we));
                chk("bus_addr",  wb_addr_o, addr);
                chk("bus_wdata", wb_data_o, wd);
                chk("bus_wstrb", 32'(wb_wstrb_o), we ? 32'(mask) : 32'h0);
                chk("bus_noack", 32'(core_ack_o), 32'h0);
                // Core fields move while busy; the adapter must ignore them.
                core_addr_i    = ~addr;
                core_wr_data_i = ~wd;
                core_mask_i    = ~mask;
                core_wr_en_i   = ~we;
                if (n_stb - 1 == ack_after) begin
                    wb_ack_i  = 1'b1;
                    wb_data_i = rd;
                end else begin
                    wb_ack_i  = 1'b0;
                    wb_data_i = $urandom;
                end
                tick();
            end else begin
                wb_ack_i = 1'b0;
                done     = 1'b1;
                chk("core_ack", 32'(core_ack_o), 32'h1);
                chk("sb_nonempty", 32'(sb.size()), 32'h1);
                if (sb.size() > 0) begin
                    g = sb.pop_front();
                    chk("rd_data",   core_rd_data_o, g.rd);
                    chk("timeout_o", 32'(timeout_o), 32'(g.to));
                end
                if (timed_out && exp_to_cnt < 255) exp_to_cnt++;
                chk("timeout_cnt", 32'(timeout_cnt_o), 32'(exp_to_cnt));
            end
        end
        if (!done) chk("xfer_done", 32'h0, 32'h1);
        lat_ack    = cyc_n - t0;
        wb_ack_i   = 1'b0;
        core_req_i = hold;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "simulation watchdog expired");
    end

    initial begin
        int ls, ns, la, sc;
        int ls2, ns2, la2, sc2;
        int ack1;

        // Reset state
        rst_n = 1'b0;
        repeat (3) tick();
        chk_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // 1. Read, slave acks on the first stb cycle
        run_xfer(1'b0, 32'h0000_0040, 32'h0, 4'hF, 0, 32'h1234_5678, 1'b0, ls, ns, la, sc);
        chk("t1_lat_stb", 32'(ls), 32'd1);
        chk("t1_n_stb",   32'(ns), 32'd1);
        chk("t1_lat_ack", 32'(la), 32'd2);
        tick();
        chk("t1_ack_pulse", 32'(core_ack_o), 32'h0);
        chk("t1_rd_hold",   core_rd_data_o, 32'h1234_5678);

        // 2. Write with three wait states
        run_xfer(1'b1, 32'h0000_0100, 32'hA5A5_A5A5, 4'b0011, 3, 32'hFFFF_FFFF, 1'b0, ls, ns, la, sc);
        chk("t2_n_stb",   32'(ns), 32'd4);
        chk("t2_lat_ack", 32'(la), 32'd5);
        tick();
        chk("t2_ack_pulse", 32'(core_ack_o), 32'h0);

        // 3. Slave never acks: abort after T stb cycles
        run_xfer(1'b0, 32'h0000_0200, 32'h0, 4'hF, -1, 32'h0, 1'b0, ls, ns, la, sc);
        chk("t3_n_stb",   32'(ns), 32'(T));
        chk("t3_lat_ack", 32'(la), 32'(T + 1));
        tick();
        chk("t3_to_pulse", 32'(timeout_o), 32'h0);
        chk("t3_stb_low",  32'(wb_stb_o), 32'h0);

        // 4. Ack on the last cycle before the abort
        run_xfer(1'b0, 32'h0000_0204, 32'h0, 4'hF, T - 1, 32'hCAFE_F00D, 1'b0, ls, ns, la, sc);
        chk("t4_n_stb", 32'(ns), 32'(T));
        tick();

        // Second abort to see the count move again
        run_xfer(1'b1, 32'h0000_0208, 32'h1111_2222, 4'b1000, -1, 32'h0, 1'b0, ls, ns, la, sc);
        tick();

        // 5. Back-to-back reads, request held through the ack
        run_xfer(1'b0, 32'h0000_0300, 32'h0, 4'hF, 0, 32'hAAAA_0001, 1'b1, ls, ns, la, sc);
        ack1 = cyc_n;
        run_xfer(1'b0, 32'h0000_0304, 32'h0, 4'hF, 0, 32'hBBBB_0002, 1'b0, ls2, ns2, la2, sc2);
        chk("t5_lat_stb2",    32'(ls2), 32'd2);
        chk("t5_stb_spacing", 32'(sc2 - sc), 32'd3);
        chk("t5_ack_to_stb",  32'(sc2 - ack1), 32'd2);
        tick();

        // 6. Reset in the middle of a bus cycle, stray ack afterwards
        core_req_i     = 1'b1;
        core_wr_en_i   = 1'b1;
        core_addr_i    = 32'h0000_0400;
        core_wr_data_i = 32'h5555_AAAA;
        core_mask_i    = 4'hF;
        tick();
        chk("t6_stb_up", 32'(wb_stb_o), 32'h1);
        core_req_i = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        chk_all_zero("t6_reset");
        exp_to_cnt = 0;
        rst_n      = 1'b1;
        wb_ack_i   = 1'b1;
        wb_data_i  = 32'h7777_7777;
        tick();
        chk("t6_stray_noack", 32'(core_ack_o), 32'h0);
        chk("t6_stray_nostb", 32'(wb_stb_o), 32'h0);
        wb_ack_i = 1'b0;
        tick();
        chk("t6_stray_noack2", 32'(core_ack_o), 32'h0);
        chk("t6_rd_still0",    core_rd_data_o, 32'h0);

        // Recovery transfer after reset
        run_xfer(1'b1, 32'h0000_0500, 32'h0BAD_F00D, 4'b0101, 1, 32'h0, 1'b0, ls, ns, la, sc);
        chk("t6_rec_lat_ack", 32'(la), 32'd3);
        tick();
        chk("sb_drained", 32'(sb.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
